// File: rtl/load_response_unit_pkg.sv
// Shared load-path types and constants for the load response unit.
// Holds funct3 encodings, the per-load metadata record and the legality rule.
package load_response_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lsb;
        logic [4:0] rd;
    } load_meta_t;

    // A load is legal when its funct3 is known and the address is naturally aligned.
    function automatic logic is_legal_load(input logic [2:0] funct3, input logic [1:0] lsb);
        logic ok_s;
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: ok_s = 1'b1;
            FUNCT3_LH, FUNCT3_LHU: ok_s = ~lsb[0];
            FUNCT3_LW:             ok_s = (lsb == 2'b00);
            default:               ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/load_meta_fifo.sv
// In-order metadata FIFO for outstanding loads; flush empties it in one cycle.
// A push is taken while full only when a pop happens in the same cycle.
module load_meta_fifo
    import load_response_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  load_meta_t               push_meta,
    input  logic                     pop,
    input  logic                     flush,
    output load_meta_t               head_meta,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    load_meta_t          mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic                push_en_s;
    logic                pop_en_s;

    // Qualify push/pop against occupancy and derive status flags.
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        count     = count_r;
        head_meta = mem_r[rd_ptr_r];
        pop_en_s  = pop && !empty;
        push_en_s = push && (!full || pop_en_s);
    end

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_en_s && !flush) begin
            mem_r[wr_ptr_r] <= push_meta;
        end
    end

endmodule

// File: rtl/load_response_unit.sv
// Load response unit: issues aligned reads, tracks outstanding loads in order and
// returns a registered, extended writeback beat; illegal loads return a fault beat.
module load_response_unit
    import load_response_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_fault,
    output logic              resp_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    load_meta_t       head_s;
    load_meta_t       push_meta_s;
    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;
    logic [CW-1:0]    drop_cnt_r;
    logic [CW-1:0]    drop_nxt_s;
    logic [CW-1:0]    outstanding_s;
    logic             legal_s;
    logic             idle_s;
    logic             pop_s;
    logic             send_s;
    logic             push_s;
    logic             flt_acc_s;
    logic             stray_s;

    // Select and extend the addressed byte/half/word from an aligned memory word.
    function automatic logic [DATA_W-1:0] extract_load(input logic [2:0]        funct3,
                                                       input logic [1:0]        lsb,
                                                       input logic [DATA_W-1:0] word);
        logic [7:0]        byte_s;
        logic [15:0]       half_s;
        logic [DATA_W-1:0] res_s;
        case (lsb)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        half_s = lsb[1] ? word[31:16] : word[15:0];
        case (funct3)
            FUNCT3_LB:  res_s = {{(DATA_W-8){byte_s[7]}}, byte_s};
            FUNCT3_LH:  res_s = {{(DATA_W-16){half_s[15]}}, half_s};
            FUNCT3_LW:  res_s = word;
            FUNCT3_LBU: res_s = {{(DATA_W-8){1'b0}}, byte_s};
            FUNCT3_LHU: res_s = {{(DATA_W-16){1'b0}}, half_s};
            default:    res_s = {DATA_W{1'b0}};
        endcase
        return res_s;
    endfunction

    load_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_meta (push_meta_s),
        .pop       (pop_s),
        .flush     (flush),
        .head_meta (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Request-side handshake; outputs are forced low while reset is asserted.
    always_comb begin
        legal_s       = is_legal_load(req_funct3, req_addr[1:0]);
        idle_s        = !flush && (drop_cnt_r == {CW{1'b0}});
        pop_s         = mem_resp_valid && !empty_s && idle_s;
        send_s        = rst_n && req_valid && legal_s && (!full_s || pop_s) && idle_s;
        push_s        = send_s && mem_req_ready;
        // Faulting loads wait for a quiet pipe so their beat cannot collide with data.
        flt_acc_s     = rst_n && req_valid && !legal_s && empty_s && !mem_resp_valid && idle_s;
        mem_req_valid = send_s;
        req_ready     = push_s || flt_acc_s;
        mem_req_addr  = rst_n ? {req_addr[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
        push_meta_s   = '{funct3: req_funct3, lsb: req_addr[1:0], rd: req_rd};
    end

    // Responses still owed by memory for flushed loads must be swallowed.
    always_comb begin
        outstanding_s = drop_cnt_r + count_s;
        stray_s       = mem_resp_valid && (outstanding_s == {CW{1'b0}});
        if (flush) begin
            drop_nxt_s = (mem_resp_valid && !stray_s) ? outstanding_s - CW'(1) : outstanding_s;
        end else if (mem_resp_valid && (drop_cnt_r != {CW{1'b0}})) begin
            drop_nxt_s = drop_cnt_r - CW'(1);
        end else begin
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Drop counter and sticky stray-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= {CW{1'b0}};
            resp_err   <= 1'b0;
        end else begin
            drop_cnt_r <= drop_nxt_s;
            if (stray_s) begin
                resp_err <= 1'b1;
            end
        end
    end

    // Registered writeback beat: load data on a popped response, or a fault beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= {DATA_W{1'b0}};
            wb_rd    <= 5'd0;
            wb_fault <= 1'b0;
        end else if (pop_s) begin
            wb_valid <= 1'b1;
            wb_data  <= extract_load(head_s.funct3, head_s.lsb, mem_resp_data);
            wb_rd    <= head_s.rd;
            wb_fault <= 1'b0;
        end else if (flt_acc_s) begin
            wb_valid <= 1'b1;
            wb_data  <= {DATA_W{1'b0}};
            wb_rd    <= req_rd;
            wb_fault <= 1'b1;
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_response_unit.sv
// Randomized scoreboard bench for load_response_unit with directed corner cases.
// The reference model tracks outstanding loads as queues and computes results arithmetically.
module tb_load_response_unit;

    localparam int DEPTH = 2;
    localparam logic [2:0] T_LB = 3'd0, T_LH = 3'd1, T_LW = 3'd2, T_LBU = 3'd4, T_LHU = 3'd5;

    logic        clk, rst_n;
    logic        req_valid, req_ready, flush;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic        wb_valid, wb_fault, resp_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    typedef struct { logic [2:0] f3; logic [1:0] lsb; logic [4:0] rd; } meta_t;
    typedef struct { logic [31:0] data; logic [4:0] rd; logic fault; } beat_t;

    meta_t       oq[$];
    beat_t       sb[$];
    logic [31:0] memq[$];
    int          dc;
    bit          err_exp;
    bit          run;
    int          checks, fails;

    load_response_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_rd(req_rd), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_fault(wb_fault),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            T_LB, T_LBU: return 1;
            T_LH, T_LHU: return 2;
            T_LW:        return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
        int s = size_of(f3);
        return (s != 0) && ((a[1:0] % s) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] w);
        int          s = size_of(f3);
        logic [31:0] v, m;
        if (s == 4) return w;
        m = (32'd1 << (8 * s)) - 32'd1;
        v = (w >> (8 * lsb)) & m;
        if ((f3 == T_LB || f3 == T_LH) && v[8*s-1]) v = v | ~m;
        return v;
    endfunction

    // One clock of stimulus: drive at negedge, check handshake, advance the model at posedge.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input bit fl, input bit mr, input bit rs, input logic [31:0] w);
        bit          pop_ok, exp_send, exp_flt, exp_ready;
        logic [31:0] rdata;
        int          tot;
        meta_t       m;
        rdata = (memq.size() > 0) ? memq[0] : $urandom;
        req_valid = v; req_addr = a; req_funct3 = f3; req_rd = rd; flush = fl;
        mem_req_ready = mr; mem_resp_valid = rs; mem_resp_data = rdata;
        #1;
        pop_ok    = rs && !fl && dc == 0 && oq.size() > 0;
        exp_send  = v && legal(f3, a) && !fl && dc == 0 && (oq.size() < DEPTH || pop_ok);
        exp_flt   = v && !legal(f3, a) && oq.size() == 0 && dc == 0 && !rs && !fl;
        exp_ready = (exp_send && mr) || exp_flt;
        chk("req_ready", req_ready, exp_ready);
        chk("mem_req_valid", mem_req_valid, exp_send);
        if (exp_send) chk("mem_req_addr", mem_req_addr, a & ~32'd3);
        @(posedge clk);
        if (rs && memq.size() > 0) void'(memq.pop_front());
        if (fl) begin
            tot = dc + oq.size();
            if (rs) begin
                if (tot > 0) tot--;
                else err_exp = 1'b1;
            end
            dc = tot;
            oq.delete();
        end else begin
            if (rs) begin
                if (dc > 0) dc--;
                else if (oq.size() > 0) begin
                    m = oq.pop_front();
                    sb.push_back('{ref_load(m.f3, m.lsb, rdata), m.rd, 1'b0});
                end else err_exp = 1'b1;
            end
            if (exp_send && mr) oq.push_back('{f3, a[1:0], rd});
            if (exp_flt) sb.push_back('{32'd0, rd, 1'b1});
        end
        if (exp_send && mr) memq.push_back(w);
        @(negedge clk);
    endtask

    task automatic idle(input bit rs);
        cycle(1'b0, 32'd0, T_LW, 5'd0, 1'b0, 1'b1, rs, 32'd0);
    endtask

    // Directed single load: issue, respond, then compare against a hand-computed constant.
    task automatic directed(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] w, input logic [31:0] exp);
        cycle(1'b1, a, f3, rd, 1'b0, 1'b1, 1'b0, w);
        idle(1'b1);
        #1;
        chk({name, "_valid"}, wb_valid, 1'b1);
        chk({name, "_data"}, wb_data, exp);
        chk({name, "_rd"}, wb_rd, rd);
    endtask

    // Monitor: every cycle the DUT beat must match the scoreboard head (or be absent).
    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && run) begin
            chk("wb_valid", wb_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (wb_valid) begin
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_fault", wb_fault, e.fault);
                end
            end
            chk("resp_err", resp_err, err_exp);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          v, fl, mr, rs;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r, sz;
        checks = 0; fails = 0; dc = 0; err_exp = 1'b0; run = 1'b0;
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h1000; req_funct3 = T_LW; req_rd = 5'd3;
        flush = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_fault", wb_fault, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        run = 1'b1;
        idle(1'b0);

        directed("lb",  T_LB,  32'h1003, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80);
        directed("lhu", T_LHU, 32'h1002, 5'd6, 32'h80FF_1234, 32'h0000_80FF);
        directed("lh",  T_LH,  32'h1002, 5'd7, 32'h80FF_1234, 32'hFFFF_80FF);
        directed("lw",  T_LW,  32'h1000, 5'd8, 32'h80FF_1234, 32'h80FF_1234);

        // Three back-to-back loads with DEPTH=2: third stalls until a response frees a slot.
        cycle(1'b1, 32'h100, T_LW, 5'd1, 1'b0, 1'b1, 1'b0, 32'hAAAA_0001);
        cycle(1'b1, 32'h104, T_LW, 5'd2, 1'b0, 1'b1, 1'b0, 32'hAAAA_0002);
        cycle(1'b1, 32'h108, T_LW, 5'd3, 1'b0, 1'b1, 1'b0, 32'hAAAA_0003);
        cycle(1'b1, 32'h108, T_LW, 5'd3, 1'b0, 1'b1, 1'b1, 32'hAAAA_0003);
        chk("b2b_outstanding", oq.size(), 2);
        idle(1'b1);
        idle(1'b1);

        // Misaligned LW waits for the outstanding load to drain, then faults.
        cycle(1'b1, 32'h2000, T_LW, 5'd9, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        cycle(1'b1, 32'h1002, T_LW, 5'd10, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 32'h1002, T_LW, 5'd10, 1'b0, 1'b1, 1'b1, 32'd0);
        cycle(1'b1, 32'h1002, T_LW, 5'd10, 1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("fault_flag", wb_fault, 1'b1);
        chk("fault_data", wb_data, 32'd0);
        chk("fault_rd", wb_rd, 5'd10);
        idle(1'b0);

        // Flush with two outstanding: both responses are swallowed, then normal service.
        cycle(1'b1, 32'h300, T_LW, 5'd11, 1'b0, 1'b1, 1'b0, 32'h5555_0001);
        cycle(1'b1, 32'h304, T_LW, 5'd12, 1'b0, 1'b1, 1'b0, 32'h5555_0002);
        cycle(1'b1, 32'h308, T_LW, 5'd13, 1'b1, 1'b1, 1'b0, 32'd0);
        idle(1'b1);
        cycle(1'b1, 32'h0, T_LBU, 5'd14, 1'b0, 1'b1, 1'b1, 32'h0000_00FF);
        directed("lbu_after_flush", T_LBU, 32'h0, 5'd14, 32'h0000_00FF, 32'h0000_00FF);

        // Response with nothing outstanding sets the sticky error.
        idle(1'b1);
        #1;
        chk("stray_resp_err", resp_err, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    f3 = T_LB;
                2:       f3 = T_LH;
                3, 4, 9: f3 = T_LW;
                5:       f3 = T_LBU;
                6:       f3 = T_LHU;
                7:       f3 = 3'd3;
                default: f3 = 3'd6;
            endcase
            a  = $urandom;
            sz = size_of(f3);
            if (sz != 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
            v  = $urandom_range(0, 2) != 0;
            fl = $urandom_range(0, 39) == 0;
            mr = $urandom_range(0, 3) != 0;
            rs = (memq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
            cycle(v, a, f3, 5'($urandom), fl, mr, rs, $urandom);
        end
        for (int i = 0; i < 8 && memq.size() > 0; i++) idle(1'b1);
        idle(1'b0);
        chk("drained_memq", memq.size(), 0);

        // Reset mid-load: outputs drop to zero immediately and state is discarded.
        cycle(1'b1, 32'h4000, T_LW, 5'd15, 1'b0, 1'b1, 1'b0, 32'h7777_7777);
        idle(1'b1);
        cycle(1'b1, 32'h4004, T_LW, 5'd16, 1'b0, 1'b1, 1'b0, 32'h8888_8888);
        #2;
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h4008; req_funct3 = T_LW; mem_resp_valid = 1'b1;
        #1;
        chk("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_wb_data", wb_data, 32'd0);
        chk("midrst_wb_rd", wb_rd, 5'd0);
        chk("midrst_resp_err", resp_err, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b0);
        chk("midrst_mem_req_valid", mem_req_valid, 1'b0);
        oq.delete(); sb.delete(); memq.delete(); dc = 0; err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; mem_resp_valid = 1'b0; req_valid = 1'b0;
        directed("lw_after_rst", T_LW, 32'h5000, 5'd17, 32'hCAFE_F00D, 32'hCAFE_F00D);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
